dev_i2c_reg_master: RTL
=======================

DEV_I2C_REG_MASTER -- requirements
Module: dev_i2c_reg_master

Interface
REQ-001 Parameter NACK_ABORT, default 1: 1 = a NACKed write byte skips the remaining bytes and goes straight to STOP; 0 = the sequence completes and only the error is flagged.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_stb  in  1  request strobe, sampled only in IDLE.
REQ-005 req_rw  in  1  0 = register write, 1 = register read.
REQ-006 req_dev  in  7  7-bit slave address.
REQ-007 req_reg  in  8  register address.
REQ-008 req_wdata  in  8  write data; ignored for reads.
REQ-009 req_ack  out  1  one-cycle pulse when a request is accepted.
REQ-010 busy  out  1  high from the cycle after accept until the cycle after rsp_val.
REQ-011 rsp_val  out  1  one-cycle completion pulse.
REQ-012 rsp_err  out  1  valid with rsp_val; 1 = at least one write byte was NACKed.
REQ-013 rsp_rdata  out  8  read result, valid with rsp_val; 0x00 for writes or on error.
REQ-014 phy_stb  out  1  command strobe to the PHY; held until phy_ack.
REQ-015 phy_mode  out  3  command code: 0 start, 1 write byte, 3 read last byte, 7 stop.
REQ-016 phy_data  out  8  byte for a write command; 0xFF otherwise.
REQ-017 phy_ack  in  1  PHY command acceptance, one cycle.
REQ-018 phy_val  in  1  PHY byte-done level; cleared by the PHY in the cycle after phy_ack.
REQ-019 phy_rdata  in  8  byte received or echoed by the PHY.
REQ-020 phy_err  in  1  PHY byte error (write NACK).

Function
REQ-021 The FSM states SHALL be: IDLE, START, DEVW, REG, WDAT, RSTART, DEVR, RDAT, STOP, WAITB, DONE.
REQ-022 In IDLE, req_stb=1 SHALL pulse req_ack and capture req_rw, req_dev, req_reg and req_wdata in the same cycle, then go to START.
REQ-023 Write sequence: START(0), DEVW(1, {dev,0}), REG(1, reg), WDAT(1, wdata), STOP(7).
REQ-024 Read sequence: START(0), DEVW(1, {dev,0}), REG(1, reg), RSTART(0), DEVR(1, {dev,1}), RDAT(3, 0xFF), STOP(7).
REQ-025 Each command state SHALL drive phy_stb=1 with a stable phy_mode and phy_data until phy_ack=1; phy_stb SHALL drop in the cycle after phy_ack.
REQ-026 Start and stop commands SHALL advance on phy_ack; byte commands SHALL go to WAITB on phy_ack.
REQ-027 WAITB SHALL ignore phy_val in its first cycle (stale level) and exit on the first subsequent cycle with phy_val=1.
REQ-028 On WAITB exit after a write byte with phy_err=1, the error flag SHALL be set; with NACK_ABORT=1 the next state SHALL be STOP, otherwise the sequence continues.
REQ-029 On WAITB exit after RDAT, phy_rdata SHALL be captured into the result register.
REQ-030 In the cycle after the STOP phy_ack, DONE SHALL pulse rsp_val with rsp_err and rsp_rdata, then return to IDLE.
REQ-031 rsp_rdata SHALL be forced to 0x00 when rsp_err=1 or req_rw=0.
REQ-032 rsp_err and rsp_rdata SHALL hold until the next accept; req_stb during busy SHALL be ignored with no req_ack.
REQ-033 A new request arriving on the same cycle as rsp_val SHALL be ignored; it is accepted in the following IDLE cycle.
REQ-034 There SHALL be no timeout: a PHY that never acks stalls the FSM indefinitely with phy_stb held high.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE and all outputs SHALL be 0, except phy_data=0xFF; the captured request and result registers SHALL be 0.
REQ-036 Reset mid-sequence SHALL abort immediately with no stop issued and no rsp_val; bus recovery is owned by the PHY reset.

Verification
REQ-037 Write dev=0x50, reg=0x10, data=0xA5, PHY model always ACKs -> phy_data sequence --,0xA0,0x10,0xA5,-- with modes 0,1,1,1,7; rsp_val=1, rsp_err=0, rsp_rdata=0x00.
REQ-038 Read dev=0x50, reg=0x02, model returns 0x3C -> modes 0,1,1,0,1,3,7 with DEVR data 0xA1; rsp_rdata=0x3C, rsp_err=0.
REQ-039 Write with NACK on REG, NACK_ABORT=1 -> WDAT is never issued, STOP follows, rsp_err=1; with NACK_ABORT=0 -> WDAT is issued and rsp_err=1.
REQ-040 phy_ack delayed 20 cycles per command and phy_val left high from the prior byte in the ack cycle -> phy_stb held stable throughout; no premature WAITB exit.
REQ-041 req_stb held high continuously -> exactly one req_ack per transaction, each separated by at least one IDLE cycle after rsp_val.
REQ-042 rst_n pulsed low during DEVR -> outputs return to their reset values asynchronously, no rsp_val, and the next request runs cleanly.

Source files
------------

// File: rtl/dev_i2c_reg_master.sv
// ---------------------------------------------------------------------------
// dev_i2c_reg_master
//
// Register-level I2C master sequencer. It accepts one register read or write
// request at a time and breaks it into byte-level commands for an external
// I2C PHY. The commands are start, write byte, read last byte and stop.
//
// Write: START, DEVW {dev,0}, REG reg, WDAT wdata, STOP
// Read : START, DEVW {dev,0}, REG reg, RSTART, DEVR {dev,1}, RDAT, STOP
//
// Parameters
//   NACK_ABORT : 1 = a NACKed write byte jumps straight to STOP,
//                0 = the sequence runs to completion and only flags the error
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_stb/rw/dev/reg/wdata
//                         request, sampled only while idle
//   req_ack               acceptance pulse (same cycle as req_stb in IDLE)
//   busy                  request in progress
//   rsp_val/err/rdata     completion pulse, NACK flag and read result
//   phy_stb/mode/data     command to the PHY, held until phy_ack
//   phy_ack               PHY accepted the command
//   phy_val/rdata/err     PHY byte-done level, received byte, write NACK
// ---------------------------------------------------------------------------
module dev_i2c_reg_master #(
    parameter int NACK_ABORT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_stb,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       req_ack,
    output logic       busy,
    output logic       rsp_val,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       phy_stb,
    output logic [2:0] phy_mode,
    output logic [7:0] phy_data,
    input  logic       phy_ack,
    input  logic       phy_val,
    input  logic [7:0] phy_rdata,
    input  logic       phy_err
);

    localparam logic [2:0] MODE_START = 3'd0;
    localparam logic [2:0] MODE_WR    = 3'd1;
    localparam logic [2:0] MODE_RD    = 3'd3;
    localparam logic [2:0] MODE_STOP  = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEVW,
        S_REG,
        S_WDAT,
        S_RSTART,
        S_DEVR,
        S_RDAT,
        S_STOP,
        S_WAITB,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    state_t     byte_q, byte_d;          // byte command that WAITB is finishing
    logic       wait_first_q, wait_first_d;
    logic       stb_q, stb_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;

    logic       is_cmd;
    logic       cmd_done;
    logic [2:0] cmd_mode;
    logic [7:0] cmd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_q       <= S_IDLE;
            wait_first_q <= 1'b0;
            stb_q        <= 1'b0;
            rw_q         <= 1'b0;
            dev_q        <= 7'h00;
            reg_q        <= 8'h00;
            wdata_q      <= 8'h00;
            err_q        <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            wait_first_q <= wait_first_d;
            stb_q        <= stb_d;
            rw_q         <= rw_d;
            dev_q        <= dev_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        wait_first_d = wait_first_q;
        rw_d         = rw_q;
        dev_d        = dev_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        req_ack      = 1'b0;
        is_cmd       = 1'b0;
        cmd_mode     = MODE_START;
        cmd_data     = 8'hFF;

        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so req_ack stays low while reset is applied.
                if (req_stb && rst_n) begin
                    req_ack = 1'b1;
                    rw_d    = req_rw;
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
                    rdata_d = 8'h00;
                    state_d = S_START;
                end
            end
            S_START, S_RSTART: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_START;
            end
            S_DEVW: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_WR;
                cmd_data = {dev_q, 1'b0};
            end
            S_REG: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_WR;
                cmd_data = reg_q;
            end
            S_WDAT: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_WR;
                cmd_data = wdata_q;
            end
            S_DEVR: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_WR;
                cmd_data = {dev_q, 1'b1};
            end
            S_RDAT: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_RD;
            end
            S_STOP: begin
                is_cmd   = 1'b1;
                cmd_mode = MODE_STOP;
            end
            S_WAITB: begin
                // phy_val may still show the previous byte's level in the
                // first cycle here, so it is only trusted from cycle two.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (phy_val) begin
                    if (byte_q == S_RDAT) begin
                        rdata_d = phy_rdata;
                        state_d = S_STOP;
                    end else begin
                        if (phy_err) begin
                            err_d = 1'b1;
                        end
                        if (phy_err && (NACK_ABORT != 0)) begin
                            state_d = S_STOP;
                        end else begin
                            case (byte_q)
                                S_DEVW:  state_d = S_REG;
                                S_REG:   state_d = rw_q ? S_RSTART : S_WDAT;
                                S_DEVR:  state_d = S_RDAT;
                                default: state_d = S_STOP;
                            endcase
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A command completes only on an ack while the strobe is actually up.
        cmd_done = is_cmd && stb_q && phy_ack;
        // Strobe rises one cycle after entering a command state and falls in
        // the cycle after the ack, giving the PHY a clean gap between commands.
        stb_d    = is_cmd && !cmd_done;

        if (cmd_done) begin
            case (state_q)
                S_START:  state_d = S_DEVW;
                S_RSTART: state_d = S_DEVR;
                S_STOP:   state_d = S_DONE;
                default: begin
                    byte_d       = state_q;
                    wait_first_d = 1'b1;
                    state_d      = S_WAITB;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rsp_val   = (state_q == S_DONE);
    assign rsp_err   = err_q;
    assign rsp_rdata = (err_q || !rw_q) ? 8'h00 : rdata_q;
    assign phy_stb   = stb_q;
    assign phy_mode  = cmd_mode;
    assign phy_data  = cmd_data;

endmodule
